// File: rtl/button_debounce.sv
// Per-channel 2-flop synchronizer, 4-state debounce FSM and press pulse for active-low buttons.
// Define BUTTON_DEBOUNCE_LONG_PRESS_EN to add per-channel hold counters driving long_press.
module button_debounce #(
   parameter int WIDTH             = 2,
   parameter int DEBOUNCE_CYCLES   = 50000,
   parameter int LONG_PRESS_CYCLES = 50000000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] btn_raw,
   output logic [WIDTH-1:0] btn_db,
   output logic [WIDTH-1:0] press_pulse,
   output logic [WIDTH-1:0] long_press
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
   localparam int                HOLD_W   = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
`endif

   typedef enum logic [1:0] {RELEASED, PEND_PRESS, PRESSED, PEND_RELEASE} state_t;

   if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 1) begin : g_param_check
      $error("button_debounce: DEBOUNCE_CYCLES must be >= 2 and LONG_PRESS_CYCLES >= 1");
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic             s1_q, s2_q;
      state_t           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             btn_db_q, btn_db_d;
      logic             press_pulse_q, press_pulse_d;

      // Counter only runs in the pending states; any revert drops it back to 0.
      always_comb begin
         state_d = state_q;
         cnt_d   = '0;
         case (state_q)
            RELEASED:
               if (!s2_q) begin
                  state_d = PEND_PRESS;
                  cnt_d   = CNT_W'(1);
               end
            PEND_PRESS:
               if (s2_q)                  state_d = RELEASED;
               else if (cnt_q == CNT_LAST) state_d = PRESSED;
               else                        cnt_d   = cnt_q + CNT_W'(1);
            PRESSED:
               if (s2_q) begin
                  state_d = PEND_RELEASE;
                  cnt_d   = CNT_W'(1);
               end
            PEND_RELEASE:
               if (!s2_q)                 state_d = PRESSED;
               else if (cnt_q == CNT_LAST) state_d = RELEASED;
               else                        cnt_d   = cnt_q + CNT_W'(1);
            default: state_d = RELEASED;
         endcase
         btn_db_d      = !(state_d == PRESSED || state_d == PEND_RELEASE);
         press_pulse_d = btn_db_q && !btn_db_d;
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            s1_q          <= 1'b1;
            s2_q          <= 1'b1;
            state_q       <= RELEASED;
            cnt_q         <= '0;
            btn_db_q      <= 1'b1;
            press_pulse_q <= 1'b0;
         end else begin
            s1_q          <= btn_raw[i];
            s2_q          <= s1_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            btn_db_q      <= btn_db_d;
            press_pulse_q <= press_pulse_d;
         end
      end

      assign btn_db[i]      = btn_db_q;
      assign press_pulse[i] = press_pulse_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
      logic [HOLD_W-1:0] hold_q, hold_d;
      logic              long_press_q, long_press_d;

      // Gate with the next btn_db so long_press drops on the same edge as the release.
      always_comb begin
         hold_d = hold_q;
         if (btn_db_q)              hold_d = '0;
         else if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
         long_press_d = !btn_db_d && (hold_d == HOLD_MAX);
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            hold_q       <= '0;
            long_press_q <= 1'b0;
         end else begin
            hold_q       <= hold_d;
            long_press_q <= long_press_d;
         end
      end

      assign long_press[i] = long_press_q;
`else
      assign long_press[i] = 1'b0;
`endif
   end

endmodule
